// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: decoded instruction flags, operand pair,
// FSM states and the access-size encoding used by the lane aligner.
package mem_stage_pkg;

  typedef struct packed {
    logic add;
    logic sub;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } instructions;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } regvpair;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

  typedef struct packed {
    size_t size;
    logic  is_unsigned;
  } access_t;

  function automatic logic is_load(instructions i);
    return i.lb | i.lh | i.lw | i.lbu | i.lhu;
  endfunction

  function automatic logic is_store(instructions i);
    return i.sb | i.sh | i.sw;
  endfunction

  function automatic access_t decode_access(instructions i);
    access_t a;
    a.is_unsigned = i.lbu | i.lhu;
    if (i.lh | i.lhu | i.sh)
      a.size = HALF;
    else if (i.lw | i.sw)
      a.size = WORD;
    else
      a.size = BYTE;
    return a;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Valid/ready request, valid-only response memory port between the stage and memory.
interface mem_stage_if #(parameter int ADDR_W = 32) ();
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_resp_valid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/data, load extraction with sign
// extension, and alignment checking for a given access size and address offset.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  size_t       i_size,
  input  logic        i_is_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misaligned
);
  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_wstrb      = '0;
    o_wdata      = '0;
    o_load_data  = '0;
    o_misaligned = 1'b0;
    case (i_size)
      BYTE: begin
        o_wstrb     = 4'b0001 << i_off;
        o_wdata     = {4{i_rs2[7:0]}};
        o_load_data = i_is_unsigned ? {24'b0, w_shifted[7:0]}
                                    : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      HALF: begin
        o_wstrb      = 4'b0011 << i_off;
        o_wdata      = {2{i_rs2[15:0]}};
        o_load_data  = i_is_unsigned ? {16'b0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
        o_misaligned = i_off[0];
      end
      WORD: begin
        o_wstrb      = 4'hF;
        o_wdata      = i_rs2;
        o_load_data  = i_rdata;
        o_misaligned = |i_off;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store per start pulse over the memory port,
// or passes the ALU result through, and reports a single-cycle completion.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enabled,
  input  instructions  instr,
  input  regvpair      register,
  input  logic [31:0]  arg,
  output logic         completed,
  output logic [31:0]  result,
  output logic         load_misaligned,
  output logic         store_misaligned,
  output logic         busy,
  mem_stage_if.master  mem
);
  state_t            r_state, w_state_next;
  access_t           r_acc;
  logic [1:0]        r_off;
  logic              r_is_load;
  logic              r_req_valid, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_result;
  logic [3:0]        r_wstrb;
  logic              r_load_mis, r_store_mis;

  access_t     w_live_acc, w_acc;
  logic        w_load, w_store, w_mem_op;
  logic [1:0]  w_off;
  logic [31:0] w_addr_full, w_wdata, w_load_data;
  logic [3:0]  w_wstrb;
  logic        w_misaligned;
  logic        w_unused;

  assign w_live_acc  = decode_access(instr);
  assign w_load      = is_load(instr);
  assign w_store     = is_store(instr);
  assign w_mem_op    = w_load | w_store;
  assign w_addr_full = {arg[31:2], 2'b00};
  assign w_unused    = ^{instr.add, instr.sub, register.rs1};

  // Live fields drive the aligner while idle; latched fields once an access is in flight.
  assign w_acc = (r_state == IDLE) ? w_live_acc : r_acc;
  assign w_off = (r_state == IDLE) ? arg[1:0]   : r_off;

  mem_lane_align u_align (
    .i_size        (w_acc.size),
    .i_is_unsigned (w_acc.is_unsigned),
    .i_off         (w_off),
    .i_rs2         (register.rs2),
    .i_rdata       (mem.mem_rdata),
    .o_wstrb       (w_wstrb),
    .o_wdata       (w_wdata),
    .o_load_data   (w_load_data),
    .o_misaligned  (w_misaligned)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enabled) w_state_next = (w_mem_op && !w_misaligned) ? REQ : DONE;
      REQ:     if (mem.mem_req_ready) w_state_next = WAIT;
      WAIT:    if (mem.mem_resp_valid) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc       <= '{size: BYTE, is_unsigned: 1'b0};
      r_off       <= '0;
      r_is_load   <= 1'b0;
      r_req_valid <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_result    <= '0;
      r_load_mis  <= 1'b0;
      r_store_mis <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (enabled) begin
          r_acc       <= w_live_acc;
          r_off       <= arg[1:0];
          r_is_load   <= w_load;
          r_load_mis  <= w_load & w_misaligned;
          r_store_mis <= w_store & w_misaligned;
          if (!w_mem_op) begin
            r_result <= arg;
          end else if (w_misaligned) begin
            r_result <= '0;
          end else begin
            r_req_valid <= 1'b1;
            r_we        <= w_store;
            r_addr      <= w_addr_full[ADDR_W-1:0];
            r_wdata     <= w_store ? w_wdata : '0;
            r_wstrb     <= w_store ? w_wstrb : '0;
          end
        end
        REQ:  if (mem.mem_req_ready) r_req_valid <= 1'b0;
        // Stores complete on the acknowledge and leave a zero result.
        WAIT: if (mem.mem_resp_valid) r_result <= r_is_load ? w_load_data : '0;
        DONE: begin
          r_load_mis  <= 1'b0;
          r_store_mis <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign completed        = (r_state == DONE);
  assign busy             = (r_state != IDLE);
  assign result           = r_result;
  assign load_misaligned  = r_load_mis;
  assign store_misaligned = r_store_mis;
  assign mem.mem_req_valid = r_req_valid;
  assign mem.mem_we        = r_we;
  assign mem.mem_addr      = r_addr;
  assign mem.mem_wdata     = r_wdata;
  assign mem.mem_wstrb     = r_wstrb;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected completions/requests,
// independent monitors compare whenever the DUT presents a request or a completion.
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  instructions instr;
  regvpair     register;
  logic [31:0] arg;
  logic        completed;
  logic [31:0] result;
  logic        load_misaligned, store_misaligned, busy;

  mem_stage_if #(.ADDR_W(32)) mem_bus ();

  mem_stage #(.ADDR_W(32)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .enabled          (enabled),
    .instr            (instr),
    .register         (register),
    .arg              (arg),
    .completed        (completed),
    .result           (result),
    .load_misaligned  (load_misaligned),
    .store_misaligned (store_misaligned),
    .busy             (busy),
    .mem              (mem_bus)
  );

  always #5 clk = ~clk;

  localparam instructions I_ADD = '{add: 1'b1, default: 1'b0};
  localparam instructions I_LB  = '{lb:  1'b1, default: 1'b0};
  localparam instructions I_LH  = '{lh:  1'b1, default: 1'b0};
  localparam instructions I_LW  = '{lw:  1'b1, default: 1'b0};
  localparam instructions I_LBU = '{lbu: 1'b1, default: 1'b0};
  localparam instructions I_LHU = '{lhu: 1'b1, default: 1'b0};
  localparam instructions I_SB  = '{sb:  1'b1, default: 1'b0};
  localparam instructions I_SH  = '{sh:  1'b1, default: 1'b0};
  localparam instructions I_SW  = '{sw:  1'b1, default: 1'b0};

  typedef struct packed {
    logic [31:0] result;
    logic        lmis;
    logic        smis;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Completion scoreboard.
  logic prev_completed = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (completed) begin
      check32("completed_one_cycle", {31'b0, prev_completed}, 32'h0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_completed: got result %h, expected no completion", result);
      end else begin
        mon_e = exp_q.pop_front();
        check32("result", result, mon_e.result);
        check32("load_misaligned", {31'b0, load_misaligned}, {31'b0, mon_e.lmis});
        check32("store_misaligned", {31'b0, store_misaligned}, {31'b0, mon_e.smis});
        $display("completion: result=%h lmis=%b smis=%b", result, load_misaligned, store_misaligned);
      end
    end else begin
      check32("flags_idle", {30'b0, load_misaligned, store_misaligned}, 32'h0);
    end
    prev_completed = completed;
  end

  // Request monitor: checks every cycle the request is held, retires it when valid drops.
  logic prev_valid = 1'b0;
  req_t mon_r;
  always @(negedge clk) begin
    if (mem_bus.mem_req_valid) begin
      if (req_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_request: got addr %h we %b, expected no request",
                 mem_bus.mem_addr, mem_bus.mem_we);
      end else begin
        mon_r = req_q[0];
        check32("req_we", {31'b0, mem_bus.mem_we}, {31'b0, mon_r.we});
        check32("req_addr", mem_bus.mem_addr, mon_r.addr);
        check32("req_wstrb", {28'b0, mem_bus.mem_wstrb}, {28'b0, mon_r.wstrb});
        if (mon_r.we) check32("req_wdata", mem_bus.mem_wdata, mon_r.wdata);
      end
    end else if (prev_valid && req_q.size() > 0) begin
      mon_r = req_q.pop_front();
      $display("request: we=%b addr=%h wdata=%h wstrb=%h", mon_r.we, mon_r.addr, mon_r.wdata, mon_r.wstrb);
    end
    prev_valid = mem_bus.mem_req_valid;
  end

  task automatic check_quiet(input string tag);
    check32({tag, "_completed"}, {31'b0, completed}, 32'h0);
    check32({tag, "_result"}, result, 32'h0);
    check32({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check32({tag, "_req_valid"}, {31'b0, mem_bus.mem_req_valid}, 32'h0);
    check32({tag, "_we"}, {31'b0, mem_bus.mem_we}, 32'h0);
    check32({tag, "_addr"}, mem_bus.mem_addr, 32'h0);
    check32({tag, "_wdata"}, mem_bus.mem_wdata, 32'h0);
    check32({tag, "_wstrb"}, {28'b0, mem_bus.mem_wstrb}, 32'h0);
  endtask

  // Issues one op and plays memory; ready is withheld ready_delay cycles once valid is seen.
  task automatic run_op(input instructions ins, input logic [31:0] rs2, input logic [31:0] a,
                        input logic [31:0] rdata, input int ready_delay, input logic exp_req,
                        input req_t rq, input exp_t ex, input int exp_lat, input logic poke);
    int   delay_left;
    logic accepted, responded, seen;
    @(negedge clk);
    #1;
    instr    = ins;
    register = '{rs1: 32'h5A5A_5A5A, rs2: rs2};
    arg      = a;
    enabled  = 1'b1;
    mem_bus.mem_req_ready = (ready_delay == 0);
    if (exp_req) req_q.push_back(rq);
    exp_q.push_back(ex);
    delay_left = ready_delay;
    accepted   = 1'b0;
    responded  = 1'b0;
    seen       = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (completed) begin
        seen = 1'b1;
        if (exp_lat > 0) check32("latency", 32'(k), 32'(exp_lat));
      end
      if (poke && k == 2) check32("busy_during_op", {31'b0, busy}, 32'h1);
      #1;
      enabled = 1'b0;
      mem_bus.mem_resp_valid = 1'b0;
      if (k == 1) begin
        instr    = I_SB;
        arg      = 32'hFFFF_FFFF;
        register = '{rs1: 32'hFFFF_FFFF, rs2: 32'h1357_9BDF};
      end
      if (poke && k == 2) begin
        instr   = I_ADD;
        arg     = 32'h5555_5555;
        enabled = 1'b1;
      end
      if (!accepted && mem_bus.mem_req_valid) begin
        if (delay_left == 0) begin
          mem_bus.mem_req_ready = 1'b1;
          accepted = 1'b1;
        end else begin
          mem_bus.mem_req_ready = 1'b0;
          delay_left--;
        end
      end else if (accepted && !responded) begin
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_rdata      = rdata;
        responded = 1'b1;
      end
    end
    mem_bus.mem_req_ready = 1'b0;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL completion_timeout: got no completed within 40 cycles, expected one");
    end
  endtask

  localparam req_t NO_REQ = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0};

  initial begin
    instr    = '0;
    register = '0;
    arg      = '0;
    mem_bus.mem_req_ready  = 1'b0;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_rdata      = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    #1 rstn = 1'b1;

    run_op(I_LB,  32'h0, 32'h0000_1003, 32'h80AA_BBCC, 0, 1'b1,
           '{we: 1'b0, addr: 32'h1000, wdata: 32'h0, wstrb: 4'h0},
           '{result: 32'hFFFF_FF80, lmis: 1'b0, smis: 1'b0}, 3, 1'b0);
    run_op(I_LHU, 32'h0, 32'h0000_2002, 32'h9234_5678, 1, 1'b1,
           '{we: 1'b0, addr: 32'h2000, wdata: 32'h0, wstrb: 4'h0},
           '{result: 32'h0000_9234, lmis: 1'b0, smis: 1'b0}, 0, 1'b0);
    run_op(I_LH,  32'h0, 32'h0000_2002, 32'h9234_5678, 0, 1'b1,
           '{we: 1'b0, addr: 32'h2000, wdata: 32'h0, wstrb: 4'h0},
           '{result: 32'hFFFF_9234, lmis: 1'b0, smis: 1'b0}, 3, 1'b0);
    run_op(I_SH,  32'hDEAD_BEEF, 32'h0000_3002, 32'h0BAD_0BAD, 3, 1'b1,
           '{we: 1'b1, addr: 32'h3000, wdata: 32'hBEEF_BEEF, wstrb: 4'b1100},
           '{result: 32'h0, lmis: 1'b0, smis: 1'b0}, 0, 1'b1);
    run_op(I_LW,  32'h0, 32'h0000_4001, 32'h0, 0, 1'b0, NO_REQ,
           '{result: 32'h0, lmis: 1'b1, smis: 1'b0}, 1, 1'b0);
    run_op(I_SW,  32'hAAAA_AAAA, 32'h0000_4002, 32'h0, 0, 1'b0, NO_REQ,
           '{result: 32'h0, lmis: 1'b0, smis: 1'b1}, 1, 1'b0);
    run_op(I_ADD, 32'h0, 32'h1234_5678, 32'h0, 0, 1'b0, NO_REQ,
           '{result: 32'h1234_5678, lmis: 1'b0, smis: 1'b0}, 1, 1'b0);
    run_op(I_SB,  32'h0000_00A5, 32'h0000_6001, 32'h0, 0, 1'b1,
           '{we: 1'b1, addr: 32'h6000, wdata: 32'hA5A5_A5A5, wstrb: 4'b0010},
           '{result: 32'h0, lmis: 1'b0, smis: 1'b0}, 3, 1'b0);
    run_op(I_LBU, 32'h0, 32'h0000_7002, 32'h11F2_3344, 2, 1'b1,
           '{we: 1'b0, addr: 32'h7000, wdata: 32'h0, wstrb: 4'h0},
           '{result: 32'h0000_00F2, lmis: 1'b0, smis: 1'b0}, 0, 1'b0);
    run_op(I_LW,  32'h0, 32'h0000_8000, 32'hCAFE_BABE, 0, 1'b1,
           '{we: 1'b0, addr: 32'h8000, wdata: 32'h0, wstrb: 4'h0},
           '{result: 32'hCAFE_BABE, lmis: 1'b0, smis: 1'b0}, 3, 1'b0);
    run_op(I_LH,  32'h0, 32'h0000_2001, 32'h0, 0, 1'b0, NO_REQ,
           '{result: 32'h0, lmis: 1'b1, smis: 1'b0}, 1, 1'b0);
    run_op(I_SW,  32'h0123_4567, 32'h0000_9000, 32'h0, 0, 1'b1,
           '{we: 1'b1, addr: 32'h9000, wdata: 32'h0123_4567, wstrb: 4'hF},
           '{result: 32'h0, lmis: 1'b0, smis: 1'b0}, 3, 1'b0);
    run_op(I_SH,  32'h0000_1111, 32'h0000_A003, 32'h0, 0, 1'b0, NO_REQ,
           '{result: 32'h0, lmis: 1'b0, smis: 1'b1}, 1, 1'b0);
    run_op(I_LB,  32'h0, 32'h0000_B000, 32'h0000_007F, 0, 1'b1,
           '{we: 1'b0, addr: 32'hB000, wdata: 32'h0, wstrb: 4'h0},
           '{result: 32'h0000_007F, lmis: 1'b0, smis: 1'b0}, 3, 1'b0);

    // Reset in WAIT, then a stray response once released.
    @(negedge clk);
    #1;
    instr   = I_LW;
    arg     = 32'h0000_5000;
    enabled = 1'b1;
    mem_bus.mem_req_ready = 1'b1;
    req_q.push_back('{we: 1'b0, addr: 32'h5000, wdata: 32'h0, wstrb: 4'h0});
    @(negedge clk);
    #1 enabled = 1'b0;
    @(negedge clk);
    check32("busy_in_wait", {31'b0, busy}, 32'h1);
    #1;
    mem_bus.mem_req_ready = 1'b0;
    rstn = 1'b0;
    #2 check_quiet("async_reset");
    @(negedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    #1;
    mem_bus.mem_resp_valid = 1'b1;
    mem_bus.mem_rdata      = 32'hDEAD_0000;
    @(negedge clk);
    #1 mem_bus.mem_resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("after_stray_resp");

    run_op(I_LW,  32'h0, 32'h0000_A004, 32'h0BAD_F00D, 0, 1'b1,
           '{we: 1'b0, addr: 32'hA004, wdata: 32'h0, wstrb: 4'h0},
           '{result: 32'h0BAD_F00D, lmis: 1'b0, smis: 1'b0}, 3, 1'b0);

    repeat (4) @(negedge clk);
    check32("pending_completions", 32'(exp_q.size()), 32'h0);
    check32("pending_requests", 32'(req_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of run, expected finish before 200us");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the ALU-computed effective address together with the decoded instruction and register operands.
- Performs byte/half/word loads and stores over a valid/ready request, valid response memory port, with lane steering, sign extension and misalignment detection.
- Non-memory instructions pass the ALU result through, so writeback sees one uniform completed/result interface.

Parameters:
- ADDR_W, 32, width of effective address and memory address bus.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- enabled  input  1  one-cycle start pulse; sampled only in IDLE.
- instr  input  instructions  decoded instruction flags (lb, lh, lw, lbu, lhu, sb, sh, sw, ...).
- register  input  regvpair  operands; rs2 supplies store data.
- arg  input  32  ALU result (effective address, or pass-through value).
- completed  output  1  one-cycle done pulse.
- result  output  32  load data or pass-through value; held until next completion.
- load_misaligned  output  1  valid with completed.
- store_misaligned  output  1  valid with completed.
- busy  output  1  high in any state other than IDLE.
- mem_req_valid  output  1  request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_we  output  1  1 = store.
- mem_addr  output  ADDR_W  word-aligned address, equal to {arg[31:2], 2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte enables; 0 for loads.
- mem_resp_valid  input  1  read data valid, or store acknowledge.
- mem_rdata  input  32  read word.

Behaviour:
- Reset (async, rstn=0): state=IDLE. completed, result, load_misaligned, store_misaligned, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb all 0.
- All inputs (instr, register, arg) are latched on enabled in IDLE and are not required to stay stable afterwards.

State machine IDLE/REQ/WAIT/DONE:
- IDLE, enabled and memory op, aligned: latch fields, drive request registers, go to REQ. mem_req_valid rises the next cycle.
- IDLE, enabled and memory op, misaligned: go to DONE. No memory request is issued. The matching misaligned flag is set and result is 0.
- IDLE, enabled and non-memory op: result <= arg, go to DONE.
- REQ: hold mem_req_valid and all request fields stable until mem_req_ready=1 at a clock edge, then drop valid and go to WAIT.
- WAIT: on mem_resp_valid, capture the extracted load data (loads only; stores keep result=0) and go to DONE. Stores also wait for the response, as a write acknowledge.
- DONE: completed=1 for exactly one cycle, flags valid, return to IDLE.
- completed is 0 in all other states. The misaligned flags are 0 whenever completed=0.
- Minimum latency, enabled to completed:
  - pass-through and misaligned: 1 cycle.
  - memory op with ready already high and response in the following cycle: 3 cycles.
- enabled while busy=1 is ignored. Upstream must not pulse it then.
- mem_resp_valid outside WAIT is ignored. This includes a late response arriving after a reset mid-operation.

Alignment (off = arg[1:0]):
- lh/lhu/sh misaligned if off[0]=1.
- lw/sw misaligned if off!=0.
- Byte ops are never misaligned.

Stores:
- sb: wstrb = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
- sh: wstrb = 4'b0011<<off, wdata = {2{rs2[15:0]}}.
- sw: wstrb = 4'hF, wdata = rs2.

Loads:
- Shift by off: sh = mem_rdata >> (8*off).
- lb = sign-extended sh[7:0].
- lbu = zero-extended sh[7:0].
- lh = sign-extended sh[15:0].
- lhu = zero-extended sh[15:0].
- lw = mem_rdata.

Other:
- Reset during REQ or WAIT aborts immediately with no completed pulse.
- Address arithmetic is not performed here; arg is used as-is, with no wrap handling needed.

Decomposition:
- def.sv (shared package/header): the state enum (IDLE, REQ, WAIT, DONE) and the access-size encoding (BYTE, HALF, WORD plus an unsigned bit), alongside the existing instructions and regvpair types.
- One combinational sub-module, mem_lane_align:
  - store direction: size/off/rs2 -> wstrb/wdata.
  - load direction: size/unsigned/off/rdata -> result.
  - misaligned detection.
  - Shared by any future cache or MMU path.

Test Plan:
- lb at arg=0x0000_1003, mem_rdata=0x80AA_BBCC -> mem_addr=0x1000, wstrb=0, result=0xFFFF_FF80, completed one cycle after resp.
- lhu at arg=0x2002, mem_rdata=0x9234_5678 -> result=0x0000_9234. lh at the same address -> result=0xFFFF_9234.
- sh at arg=0x3002, rs2=0xDEAD_BEEF -> wstrb=4'b1100, wdata=0xBEEF_BEEF, mem_we=1. mem_req_ready held low 3 cycles -> request fields stable throughout, completed only after resp.
- lw at arg=0x4001 -> no mem_req_valid, completed next cycle with load_misaligned=1, result=0. sw at 0x4002 -> store_misaligned=1.
- add pass-through with arg=0x1234_5678 -> completed next cycle, result=0x1234_5678, no memory traffic. enabled pulsed while busy -> ignored.
- rstn pulled low during WAIT, then a stray mem_resp_valid after release -> outputs 0, no completed pulse, next lw completes normally.
